// File: rtl/heartbeat_monitor_pkg.sv
// Shared helpers for the heartbeat receive checker.
package heartbeat_monitor_pkg;

    // Widened to 33 bits so a tolerance larger than the half period cannot wrap.
    function automatic logic in_window(
        input logic [31:0] n,
        input logic [31:0] half,
        input logic [31:0] tol
    );
        logic [32:0] n33;
        logic [32:0] h33;
        logic [32:0] t33;
        n33 = {1'b0, n};
        h33 = {1'b0, half};
        t33 = {1'b0, tol};
        return ((n33 + t33) >= h33) && (n33 <= (h33 + t33));
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer, asynchronous active-high reset to 0.
module sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/heartbeat_monitor.sv
// Far-end heartbeat checker: measures toggle intervals, locks after a run
// of good intervals and flags loss when the toggles stop.
module heartbeat_monitor
    import heartbeat_monitor_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 10000000,
    parameter int unsigned TOLERANCE   = 1000000,
    parameter int unsigned TIMEOUT     = 30000000,
    parameter int unsigned GOOD_NEEDED = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HB_IN,
    output logic        ALIVE,
    output logic        LOST,
    output logic [31:0] INTERVAL,
    output logic        INTERVAL_VALID,
    output logic        BAD_INTERVAL,
    output logic [31:0] EDGE_COUNT
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_LOST    = 2'd3;

    localparam logic [31:0] HALF = 32'(HALF_PERIOD);
    localparam logic [31:0] TOL  = 32'(TOLERANCE);
    localparam logic [31:0] TMO  = 32'(TIMEOUT);
    localparam logic [3:0]  GN   = 4'(GOOD_NEEDED);

    logic        hb_sync;
    logic        hb_hist;
    logic        strobe;
    logic [31:0] cnt;
    logic [1:0]  state;
    logic [3:0]  good_cnt;
    logic        good;
    logic        timeout;

    sync2 u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (HB_IN),
        .Q     (hb_sync)
    );

    assign strobe  = hb_sync != hb_hist;
    assign good    = in_window(cnt, HALF, TOL);
    assign timeout = cnt == TMO;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hb_hist <= 1'b0;
            cnt     <= '0;
        end else begin
            hb_hist <= hb_sync;
            if (strobe)
                cnt <= 32'd1;
            else if (!timeout)
                cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= S_IDLE;
            good_cnt       <= '0;
            ALIVE          <= 1'b0;
            LOST           <= 1'b0;
            INTERVAL       <= '0;
            INTERVAL_VALID <= 1'b0;
            BAD_INTERVAL   <= 1'b0;
            EDGE_COUNT     <= '0;
        end else begin
            INTERVAL_VALID <= 1'b0;
            BAD_INTERVAL   <= 1'b0;
            // A strobe always takes priority over a coincident timeout.
            if (strobe) begin
                EDGE_COUNT <= EDGE_COUNT + 32'd1;
                case (state)
                    S_ACQUIRE: begin
                        INTERVAL       <= cnt;
                        INTERVAL_VALID <= 1'b1;
                        if (good) begin
                            if (good_cnt + 4'd1 == GN) begin
                                state    <= S_LOCKED;
                                ALIVE    <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else begin
                            BAD_INTERVAL <= 1'b1;
                            good_cnt     <= '0;
                        end
                    end
                    S_LOCKED: begin
                        INTERVAL       <= cnt;
                        INTERVAL_VALID <= 1'b1;
                        if (!good) begin
                            BAD_INTERVAL <= 1'b1;
                            state        <= S_ACQUIRE;
                            good_cnt     <= '0;
                            ALIVE        <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_ACQUIRE;
                        good_cnt <= '0;
                        LOST     <= 1'b0;
                    end
                endcase
            end else if (timeout && state != S_LOST) begin
                state    <= S_LOST;
                good_cnt <= '0;
                LOST     <= 1'b1;
                ALIVE    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor with an interval scoreboard.
module tb_heartbeat_monitor;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        HB_IN = 1'b0;
    logic        ALIVE;
    logic        LOST;
    logic [31:0] INTERVAL;
    logic        INTERVAL_VALID;
    logic        BAD_INTERVAL;
    logic [31:0] EDGE_COUNT;

    heartbeat_monitor #(
        .HALF_PERIOD (100),
        .TOLERANCE   (10),
        .TIMEOUT     (300),
        .GOOD_NEEDED (3)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .HB_IN          (HB_IN),
        .ALIVE          (ALIVE),
        .LOST           (LOST),
        .INTERVAL       (INTERVAL),
        .INTERVAL_VALID (INTERVAL_VALID),
        .BAD_INTERVAL   (BAD_INTERVAL),
        .EDGE_COUNT     (EDGE_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] iv;
        logic        bad;
        logic        alive;
        logic [31:0] ec;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = 0;

    typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_LOST} mstate_t;
    mstate_t m_state = M_IDLE;
    int m_good = 0;
    int m_edges = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Toggle the heartbeat and advance the reference model by one edge.
    task automatic tog();
        int  gap;
        logic ok;
        exp_t e;
        gap = cyc - last_cyc;
        last_cyc = cyc;
        HB_IN = ~HB_IN;
        m_edges++;
        if (gap > 300) m_state = M_LOST;
        ok = (gap >= 90) && (gap <= 110);
        case (m_state)
            M_ACQ: begin
                if (ok) begin
                    m_good++;
                    if (m_good == 3) m_state = M_LOCK;
                end else begin
                    m_good = 0;
                end
            end
            M_LOCK: begin
                if (!ok) begin
                    m_state = M_ACQ;
                    m_good = 0;
                end
            end
            default: begin
                m_state = M_ACQ;
                m_good = 0;
                return;
            end
        endcase
        e.iv = 32'(gap);
        e.bad = !ok;
        e.alive = m_state == M_LOCK;
        e.ec = 32'(m_edges);
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (BAD_INTERVAL && !INTERVAL_VALID)
                chk("bad_without_valid", 32'(BAD_INTERVAL), 32'd0);
            if (INTERVAL_VALID) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(INTERVAL_VALID), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("interval", INTERVAL, e.iv);
                    chk("bad_pulse", 32'(BAD_INTERVAL), 32'(e.bad));
                    chk("alive_at_valid", 32'(ALIVE), 32'(e.alive));
                    chk("edge_count_at_valid", EDGE_COUNT, e.ec);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic seen;
        logic alive_prev;

        // Reset with no toggles: everything quiet until LOST.
        tick(3);
        chk("rst_alive", 32'(ALIVE), 32'd0);
        chk("rst_lost", 32'(LOST), 32'd0);
        chk("rst_interval", INTERVAL, 32'd0);
        chk("rst_valid", 32'(INTERVAL_VALID), 32'd0);
        chk("rst_bad", 32'(BAD_INTERVAL), 32'd0);
        chk("rst_edges", EDGE_COUNT, 32'd0);
        RESET = 1'b0;
        seen = 1'b0;
        for (k = 1; k <= 400; k++) begin
            tick(1);
            if (ALIVE || INTERVAL_VALID || BAD_INTERVAL || EDGE_COUNT != 0)
                seen = 1'b1;
            if (LOST) break;
        end
        chk("quiet_before_lost", 32'(seen), 32'd0);
        chk("lost_delay_from_reset", 32'(k), 32'd301);
        m_state = M_LOST;

        // Lock on 100-cycle intervals.
        tog();
        tick(4);
        chk("lost_cleared", 32'(LOST), 32'd0);
        chk("first_edge_count", EDGE_COUNT, 32'd1);
        tick(96); tog();
        tick(100); tog();
        tick(4);
        chk("alive_before_third", 32'(ALIVE), 32'd0);
        tick(96); tog();
        tick(4);
        chk("lock_alive", 32'(ALIVE), 32'd1);
        chk("lock_edges", EDGE_COUNT, 32'd4);

        // One long interval while locked, then relock.
        tick(116); tog();
        tick(4);
        chk("bad_drops_alive", 32'(ALIVE), 32'd0);
        tick(96); tog();
        tick(100); tog();
        tick(100); tog();
        tick(4);
        chk("relock_alive", 32'(ALIVE), 32'd1);

        // Tolerance edges.
        tick(86); tog();
        tick(110); tog();
        tick(4);
        chk("bound_good_alive", 32'(ALIVE), 32'd1);
        tick(85); tog();
        tick(111); tog();
        tick(90); tog();
        tick(110); tog();
        tick(100); tog();
        tick(4);
        chk("bound_relock", 32'(ALIVE), 32'd1);

        // Stop toggling: loss after timeout, then recovery.
        alive_prev = ALIVE;
        for (k = 5; k <= 400; k++) begin
            alive_prev = ALIVE;
            tick(1);
            if (LOST) break;
        end
        chk("lost_delay_from_toggle", 32'(k), 32'd303);
        chk("alive_before_lost", 32'(alive_prev), 32'd1);
        chk("alive_at_lost", 32'(ALIVE), 32'd0);
        tog();
        tick(4);
        chk("recover_lost_clear", 32'(LOST), 32'd0);
        tick(96); tog();
        tick(100); tog();
        tick(100); tog();
        tick(4);
        chk("recover_alive", 32'(ALIVE), 32'd1);

        // Asynchronous reset between clock edges while locked.
        tick(50);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_alive", 32'(ALIVE), 32'd0);
        chk("async_lost", 32'(LOST), 32'd0);
        chk("async_interval", INTERVAL, 32'd0);
        chk("async_edges", EDGE_COUNT, 32'd0);
        chk("pending_at_reset", 32'(q.size()), 32'd0);
        HB_IN = 1'b0;
        m_state = M_IDLE;
        m_good = 0;
        m_edges = 0;
        tick(3);
        RESET = 1'b0;
        tick(20); tog();
        tick(100); tog();
        tick(100); tog();
        tick(100); tog();
        tick(4);
        chk("reacq_alive", 32'(ALIVE), 32'd1);
        chk("reacq_edges", EDGE_COUNT, 32'd4);

        tick(10);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
